// File: rtl/vrlp_pkg.sv
// Shared constants and state encoding for the VRLP deframer.
package vrlp_pkg;

    localparam logic [31:0] DEF_VRLP_MAGIC = 32'h5652_4C50;
    localparam logic [31:0] DEF_VEND_MAGIC = 32'h5645_4E44;

    localparam int unsigned MAGIC_HI = 63;
    localparam int unsigned MAGIC_LO = 32;
    localparam int unsigned LEN_HI   = 19;
    localparam int unsigned LEN_LO   = 0;
    localparam int unsigned LEN_W    = 20;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/axis_lookahead_reg.sv
// One-line hold register: a line leaves only when its successor arrives,
// so the successor's tlast becomes the held line's tlast.
module axis_lookahead_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        active,
    input  logic [63:0] in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        hold_valid
);

    logic [63:0] hold;
    logic        take;

    assign in_ready  = !hold_valid || out_ready;
    assign out_valid = active && hold_valid && in_valid;
    assign out_data  = hold;
    assign out_last  = in_last;
    assign take      = active && in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (clear) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (take) begin
            if (in_last) begin
                hold_valid <= 1'b0;
            end else begin
                hold       <= in_data;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vrlp_to_cvita.sv
// Strips VRLP header/trailer lines and forwards the enclosed CVITA packet.
// Optional VRLP_TO_CVITA_LEN_CHECK_EN verifies vrlp_len against the body line count.
module vrlp_to_cvita
    import vrlp_pkg::*;
#(
    parameter logic [31:0] VRLP_MAGIC = DEF_VRLP_MAGIC,
    parameter logic [31:0] VEND_MAGIC = DEF_VEND_MAGIC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [63:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        o_err
);

    state_t state;
    logic   body_ready;
    logic   hold_valid;
    logic   accept;
    logic   magic_ok;
    logic   vend_ok;
    logic   len_bad;
    logic   trailer_err;

    axis_lookahead_reg u_hold (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .active     (state == BODY),
        .in_data    (i_tdata),
        .in_last    (i_tlast),
        .in_valid   (i_tvalid),
        .in_ready   (body_ready),
        .out_data   (o_tdata),
        .out_last   (o_tlast),
        .out_valid  (o_tvalid),
        .out_ready  (o_tready),
        .hold_valid (hold_valid)
    );

    assign i_tready = (state == BODY) ? body_ready : 1'b1;
    assign accept   = i_tvalid && i_tready;
    assign magic_ok = i_tdata[MAGIC_HI:MAGIC_LO] == VRLP_MAGIC;
    assign vend_ok  = i_tdata[MAGIC_HI:MAGIC_LO] == VEND_MAGIC;

`ifdef VRLP_TO_CVITA_LEN_CHECK_EN
    logic [LEN_W-1:0] len_exp;
    logic [LEN_W-1:0] n_lines;

    // Expected word count is 2N+3; compare one bit wider so it cannot wrap.
    assign len_bad = ({n_lines, 1'b0} + 21'd3) != {1'b0, len_exp};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_exp <= '0;
            n_lines <= '0;
        end else if (clear) begin
            len_exp <= '0;
            n_lines <= '0;
        end else if (accept) begin
            if (state == HDR) begin
                len_exp <= i_tdata[LEN_HI:LEN_LO];
                n_lines <= '0;
            end else if (state == BODY && !i_tlast) begin
                n_lines <= n_lines + 1'b1;
            end
        end
    end
`else
    assign len_bad = 1'b0;
`endif

    assign trailer_err = !hold_valid || !vend_ok || len_bad;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HDR;
            o_err <= 1'b0;
        end else if (clear) begin
            state <= HDR;
            o_err <= 1'b0;
        end else begin
            o_err <= 1'b0;
            if (accept) begin
                case (state)
                    HDR: begin
                        if (i_tlast) begin
                            o_err <= 1'b1;
                        end else if (magic_ok) begin
                            state <= BODY;
                        end else begin
                            state <= DROP;
                            o_err <= 1'b1;
                        end
                    end
                    BODY: begin
                        if (i_tlast) begin
                            state <= HDR;
                            o_err <= trailer_err;
                        end
                    end
                    DROP: begin
                        if (i_tlast) state <= HDR;
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vrlp_to_cvita.sv
// Scoreboard bench for vrlp_to_cvita: expected CVITA beats queued at drive time.
module tb_vrlp_to_cvita;
    import vrlp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [63:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        o_err;

    always #5 clk = ~clk;

    vrlp_to_cvita dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_err    (o_err)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [64:0] exp_q[$];
    int unsigned err_seen = 0;
    int unsigned exp_err  = 0;
    int unsigned out_seen = 0;
    int unsigned exp_out  = 0;
    logic        timed_out = 1'b0;
    logic        bp_done;
    logic        stall_prev = 1'b0;
    logic [64:0] prev_beat = '0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: samples on the falling edge, inputs change just after the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (o_err) err_seen++;
            if (stall_prev) begin
                check("stall_valid", 65'(o_tvalid), 65'd1);
                check("stall_data", {o_tlast, o_tdata}, prev_beat);
            end
            if (o_tvalid && o_tready) begin
                out_seen++;
                if (exp_q.size() == 0) check("unexpected_beat", 65'(exp_q.size() + 1), 65'd0);
                else check("beat", {o_tlast, o_tdata}, exp_q.pop_front());
            end
            stall_prev = o_tvalid && !o_tready;
            prev_beat  = {o_tlast, o_tdata};
        end
    end

    task automatic send_line(input logic [63:0] d, input logic l);
        int unsigned n = 0;
        if (timed_out) return;
        i_tdata  = d;
        i_tlast  = l;
        i_tvalid = 1'b1;
        @(negedge clk);
        while (!i_tready) begin
            n++;
            if (n > 2000) begin
                check("ready_timeout", 65'(n), 65'd0);
                timed_out = 1'b1;
                i_tvalid  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] first, input int n, input logic [31:0] vmagic,
                              input logic [31:0] tmagic, input logic [19:0] len);
        logic        good;
        logic        len_bad;
        logic [63:0] d;
        good = (vmagic == DEF_VRLP_MAGIC);
`ifdef VRLP_TO_CVITA_LEN_CHECK_EN
        len_bad = (len != 20'(2 * n + 3));
`else
        len_bad = 1'b0;
`endif
        send_line({vmagic, 12'h000, len}, 1'b0);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? first : 64'hAAAA_BBBB_CCCC_0000 + 64'(i - 1);
            if (good) begin
                exp_q.push_back({(i == n - 1), d});
                exp_out++;
            end
            send_line(d, 1'b0);
        end
        send_line({tmagic, 32'h0}, 1'b1);
        if (!good) exp_err++;
        else if (n == 0 || tmagic != DEF_VEND_MAGIC || len_bad) exp_err++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle(input string tag);
        idle(5);
        check({tag, "_errs"}, 65'(err_seen), 65'(exp_err));
        check({tag, "_outs"}, 65'(out_seen), 65'(exp_out));
    endtask

    initial begin
        reset    = 1'b0;
        clear    = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        bp_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 65'(o_tvalid), 65'd0);
        check("rst_err", 65'(o_err), 65'd0);
        check("rst_tdata", 65'(o_tdata), 65'd0);
        check("rst_tready", 65'(i_tready), 65'd1);
        reset = 1'b1;
        idle(2);

        // nominal frame
        send_frame(64'hAABC_0008_DEAD_BEEF, 4, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h00B);
        settle("nominal");

        // output blocked while four frames are offered
        o_tready = 1'b0;
        fork
            begin
                send_frame(64'h7DEF_0008_0000_0001, 4, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h00B);
                send_frame(64'hAABC_0007_0000_0002, 4, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h00B);
                send_frame(64'h7DEF_0007_0000_0003, 4, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h00B);
                send_frame(64'hAABC_0008_0000_0004, 4, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h00B);
            end
            begin
                repeat (30) @(posedge clk);
                #2;
                o_tready = 1'b1;
            end
        join
        settle("backpressure");

        // random output stalls across frames of varying length
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send_frame(64'h1234_0000_0000_0000 + 64'(k), 1 + (k % 5),
                               DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'(2 * (1 + (k % 5)) + 3));
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #2;
                    o_tready = 1'($urandom_range(0, 1));
                end
                o_tready = 1'b1;
            end
        join
        settle("random_bp");

        // bad header magic, then a good frame
        send_frame(64'hAABC_0008_1111_1111, 3, 32'h1234_5678, DEF_VEND_MAGIC, 20'h009);
        send_frame(64'hAABC_0008_2222_2222, 2, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h007);
        settle("bad_magic");

        // tlast on the header line
        send_line({DEF_VRLP_MAGIC, 32'h0000_0003}, 1'b1);
        exp_err++;
        send_frame(64'hAABC_0008_3333_3333, 1, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h005);
        settle("hdr_last");

        // bad trailer
        send_frame(64'hAABC_0008_4444_4444, 3, DEF_VRLP_MAGIC, 32'hDEAD_BEEF, 20'h009);
        settle("bad_trailer");

        // empty frame, and a length mismatch that only the length check flags
        send_frame(64'h0, 0, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h003);
        send_frame(64'hAABC_0008_5555_5555, 4, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h00D);
        settle("empty_len");

        // async reset after two body lines
        send_line({DEF_VRLP_MAGIC, 32'h0000_000B}, 1'b0);
        exp_q.push_back({1'b0, 64'h6666_0000_0000_0001});
        exp_out++;
        send_line(64'h6666_0000_0000_0001, 1'b0);
        send_line(64'h6666_0000_0000_0002, 1'b0);
        reset = 1'b0;
        idle(2);
        check("mid_rst_tvalid", 65'(o_tvalid), 65'd0);
        reset = 1'b1;
        idle(1);
        send_frame(64'hAABC_0008_7777_7777, 2, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h007);
        settle("mid_reset");

        // synchronous clear after two body lines
        send_line({DEF_VRLP_MAGIC, 32'h0000_000B}, 1'b0);
        exp_q.push_back({1'b0, 64'h8888_0000_0000_0001});
        exp_out++;
        send_line(64'h8888_0000_0000_0001, 1'b0);
        send_line(64'h8888_0000_0000_0002, 1'b0);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check("mid_clr_tvalid", 65'(o_tvalid), 65'd0);
        send_frame(64'hAABC_0008_9999_9999, 3, DEF_VRLP_MAGIC, DEF_VEND_MAGIC, 20'h009);
        settle("mid_clear");

        check("queue_drained", 65'(exp_q.size()), 65'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
